fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined CPU: PC register, next-PC selection, and the IF/ID pipeline register feeding the decode/control stage.
- Consumes the control unit's active-low STALL (0 = stall) and active-low Condep (0 = flush), plus the PC-source select and redirect targets.
- Drives the combinational instruction-memory address and holds decode-side instruction/PC+4.
- Carries saturating performance counters for fetch, stall and flush events.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
NOP_INST, 32'h00000000, instruction word injected into IF/ID on flush/reset
CNT_W, 16, width of each performance counter

Ports:
Clk  input  1  clock, all state updates on rising edge
Rst  input  1  asynchronous active-high reset
STALL  input  1  active-low stall from control unit; 0 = hold PC and IF/ID
Condep  input  1  active-low flush from control unit; 0 = squash IF/ID contents
Pcsrc  input  2  next-PC select: 00 PC+4, 10 branch target, 11 jump target, 01 treated as PC+4
BrAddr  input  32  branch target address
JAddr  input  32  jump target address
ImemData  input  32  instruction word read combinationally at ImemAddr
ImemAddr  output  32  current PC (= PC register)
InstD  output  32  IF/ID instruction register
Pc4D  output  32  IF/ID PC+4 register
ValidD  output  1  IF/ID holds a real fetched instruction
AlignErr  output  1  sticky: a redirect target with nonzero [1:0] was taken
FetchCnt  output  CNT_W  instructions loaded into IF/ID
StallCnt  output  CNT_W  cycles held by stall
FlushCnt  output  CNT_W  cycles IF/ID was flushed

Behaviour:
- Reset (Rst=1, asynchronous, any time, including mid-redirect):
  - PC=RESET_PC, InstD=NOP_INST, Pc4D=0, ValidD=0, AlignErr=0, all counters=0.
  - First edge after deassert fetches RESET_PC.
- ImemAddr = PC combinationally; pc4 = PC+4, 32-bit modulo: 32'hFFFFFFFC wraps to 32'h00000000.
- PC update per edge, priority order:
  1. Pcsrc==10 → PC ≤ {BrAddr[31:2],2'b00}.
  2. Pcsrc==11 → PC ≤ {JAddr[31:2],2'b00}.
  3. STALL==0 → PC holds.
  4. Otherwise → PC ≤ pc4.
- Redirect beats stall: a simultaneous redirect and stall must redirect, because the stalled decode instruction is being squashed.
- AlignErr set on any edge where rule 1 or 2 fires and the chosen target has [1:0]≠0; it stays set until reset.
- IF/ID update per edge, priority order:
  1. Condep==0 → InstD ≤ NOP_INST, Pc4D ≤ 0, ValidD ≤ 0.
  2. STALL==0 → hold all three.
  3. Otherwise → InstD ≤ ImemData, Pc4D ≤ pc4, ValidD ≤ 1.
- Flush with stall: flush wins.
- Latency: instruction at PC appears on InstD one edge after PC is presented. A redirect takes effect on the next edge; the wrong-path word fetched in that cycle is squashed only if Condep==0 in the same cycle (control unit asserts both together).
- Counters (saturate at all-ones, never wrap):
  - FetchCnt +1 on each edge taking IF/ID rule 3.
  - StallCnt +1 on each edge with STALL==0 and Condep==1.
  - FlushCnt +1 on each edge with Condep==0.
- No combinational path from STALL/Condep to InstD/Pc4D/ValidD.
- X on ImemData is allowed only when IF/ID does not load.

Test Plan:
- Reset then 4 free-running edges, STALL=1, Condep=1, Pcsrc=00, ImemData=PC-tagged words → ImemAddr 0,4,8,C,10; InstD follows one edge behind; ValidD=0 then 1; FetchCnt=4.
- STALL=0 for 2 edges at PC=8 → PC stays 8, InstD/Pc4D unchanged, StallCnt=2, FetchCnt unchanged; STALL=1 → PC=C next edge.
- Pcsrc=10, BrAddr=32'h40, Condep=0, STALL=0 simultaneously → PC=40, InstD=NOP_INST, ValidD=0, FlushCnt+1, StallCnt unchanged; next edge InstD=word@40, Pc4D=44.
- Pcsrc=11, JAddr=32'h103 → PC=100, AlignErr=1; stays 1 across later edges until Rst.
- Force PC=FFFFFFFC via jump, then free-run → ImemAddr 0 next edge, Pc4D=0 for that fetch.
- Rst pulsed mid-cycle with STALL=0 and Pcsrc=10 → outputs drop to reset values immediately without a clock edge. Separately, force StallCnt to all-ones with CNT_W=4 (16 stall cycles) → StallCnt stays 4'hF.

Source files
------------

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the 5-stage pipelined CPU. It holds the PC,
// picks the next PC (sequential, branch, jump or hold), presents the PC to
// instruction memory combinationally, and latches the returned word together
// with PC+4 into the IF/ID register for the decode stage. Three saturating
// counters record fetch, stall and flush events.
//
// Ports
//   Clk       clock; all state changes on the rising edge
//   Rst       asynchronous active-high reset
//   STALL     active-low stall: 0 holds the PC and IF/ID
//   Condep    active-low flush: 0 replaces the IF/ID contents with a bubble
//   Pcsrc     next-PC select: 00/01 PC+4, 10 branch target, 11 jump target
//   BrAddr    branch target address
//   JAddr     jump target address
//   ImemData  instruction word that memory returns for ImemAddr
//   ImemAddr  current PC
//   InstD     IF/ID instruction
//   Pc4D      IF/ID PC+4
//   ValidD    IF/ID holds a real fetched instruction
//   AlignErr  sticky flag: a redirect to a target with nonzero [1:0] was taken
//   FetchCnt  instructions loaded into IF/ID (saturating)
//   StallCnt  cycles held by a stall without a flush (saturating)
//   FlushCnt  cycles in which IF/ID was flushed (saturating)
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             STALL,
  input  logic             Condep,
  input  logic [1:0]       Pcsrc,
  input  logic [31:0]      BrAddr,
  input  logic [31:0]      JAddr,
  input  logic [31:0]      ImemData,
  output logic [31:0]      ImemAddr,
  output logic [31:0]      InstD,
  output logic [31:0]      Pc4D,
  output logic             ValidD,
  output logic             AlignErr,
  output logic [CNT_W-1:0] FetchCnt,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  // Source that feeds the PC register on the next edge.
  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_HOLD = 2'b01,
    PC_BR   = 2'b10,
    PC_JMP  = 2'b11
  } pc_sel_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [31:0] pc_q;
  logic [31:0] pc_next;
  logic [31:0] pc4;
  logic [31:0] redirect_tgt;
  pc_sel_t     pc_sel;
  logic        redirect;
  logic        tgt_misaligned;
  logic        stall;
  logic        flush;
  logic        load_ifid;
  logic        fetch_inc;
  logic        stall_inc;
  logic        flush_inc;

  assign stall    = ~STALL;
  assign flush    = ~Condep;
  assign ImemAddr = pc_q;

  // Plain 32-bit add, so PC 32'hFFFFFFFC wraps to 0.
  assign pc4 = pc_q + 32'd4;

  // Next-PC selection. A redirect beats a stall: when both arrive together
  // the stalled decode instruction is on the wrong path and is being
  // squashed, so holding the PC would lose the redirect.
  always_comb begin
    pc_sel       = PC_SEQ;
    redirect     = 1'b0;
    redirect_tgt = JAddr;
    if (Pcsrc == 2'b10) begin
      pc_sel       = PC_BR;
      redirect     = 1'b1;
      redirect_tgt = BrAddr;
    end else if (Pcsrc == 2'b11) begin
      pc_sel       = PC_JMP;
      redirect     = 1'b1;
      redirect_tgt = JAddr;
    end else if (stall) begin
      pc_sel = PC_HOLD;
    end
  end

  assign tgt_misaligned = redirect && (redirect_tgt[1:0] != 2'b00);

  // Redirect targets are forced word-aligned; the misalignment is only
  // reported through AlignErr.
  always_comb begin
    pc_next = pc4;
    case (pc_sel)
      PC_SEQ:  pc_next = pc4;
      PC_HOLD: pc_next = pc_q;
      PC_BR:   pc_next = {BrAddr[31:2], 2'b00};
      PC_JMP:  pc_next = {JAddr[31:2], 2'b00};
      default: pc_next = pc4;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_next;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      AlignErr <= 1'b0;
    end else if (tgt_misaligned) begin
      AlignErr <= 1'b1;
    end
  end

  // IF/ID register. Flush wins over stall; ImemData is only sampled when
  // the register actually loads.
  assign load_ifid = Condep & STALL;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      InstD  <= NOP_INST;
      Pc4D   <= 32'h0000_0000;
      ValidD <= 1'b0;
    end else if (flush) begin
      InstD  <= NOP_INST;
      Pc4D   <= 32'h0000_0000;
      ValidD <= 1'b0;
    end else if (load_ifid) begin
      InstD  <= ImemData;
      Pc4D   <= pc4;
      ValidD <= 1'b1;
    end
  end

  // Performance counters, each sticking at all-ones instead of wrapping.
  assign fetch_inc = load_ifid;
  assign stall_inc = stall & Condep;
  assign flush_inc = flush;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      FetchCnt <= '0;
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (fetch_inc && (FetchCnt != CNT_MAX)) begin
        FetchCnt <= FetchCnt + CNT_ONE;
      end
      if (stall_inc && (StallCnt != CNT_MAX)) begin
        StallCnt <= StallCnt + CNT_ONE;
      end
      if (flush_inc && (FlushCnt != CNT_MAX)) begin
        FlushCnt <= FlushCnt + CNT_ONE;
      end
    end
  end

endmodule
